ms_muldiv_seq: RTL and testbench

- Parametrised, sequential, radix-2 integer arithmetic unit.
- Successor to the fixed-width signed multiplier on the board top-level.
- Adds operand width as a parameter, a 4-way operation select (signed/unsigned multiply and divide), divide-by-zero flagging and a completion pulse.
- Sits between the switch bank (operands) and the LED bank (result). Same start/ready handshake style as the previous generation.

---
 rtl/ms_muldiv_seq_pkg.sv | 26 ++
 rtl/ms_muldiv_seq_if.sv | 20 ++
 rtl/ms_muldiv_seq_start_sync.sv | 26 ++
 rtl/ms_muldiv_seq.sv | 140 ++++++++++++++
 tb/tb_ms_muldiv_seq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ms_muldiv_seq_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
package pkg_mult;

    localparam int DW_DEF  = 16;
    localparam int DW2_DEF = 2 * DW_DEF;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Input is pre-extended to 33 bits; callers keep the low DW+1 bits, which
    // is enough to hold |-2^(DW-1)| without overflow.
    function automatic logic [32:0] abs_ext(input logic signed [32:0] v);
        return v[32] ? 33'(-v) : 33'(v);
    endfunction

endpackage

// File: rtl/ms_muldiv_seq_if.sv
// Operand/result bus between the switch bank, the arithmetic unit and the LED bank.
interface ms_muldiv_seq_if
    import pkg_mult::*;
#(
    parameter int DW = DW_DEF
);
    localparam int DW2 = 2 * DW;

    logic           i_start;
    logic [1:0]     i_op;
    logic [DW2-1:0] i_sw;
    logic [DW2-1:0] o_led;
    logic           o_ready;
    logic           o_done;
    logic           o_err;

    modport master (output i_start, i_op, i_sw, input o_led, o_ready, o_done, o_err);
    modport slave  (input i_start, i_op, i_sw, output o_led, o_ready, o_done, o_err);

endinterface

// File: rtl/ms_muldiv_seq_start_sync.sv
// Synchronises the active-low push-button start and emits one pulse per falling edge.
module ms_start_sync
    import pkg_mult::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_accept
);

    // Bits [SYNC_STAGES-1:0] are the synchroniser; the top bit is the edge-detect history.
    logic [SYNC_STAGES:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-1:0], i_start};
        end
    end

    assign o_accept = r_sync[SYNC_STAGES] & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ms_muldiv_seq.sv
// Radix-2 sequential signed/unsigned multiply and restoring divide, one bit per clock.
module ms_muldiv_seq
    import pkg_mult::*;
#(
    parameter int  DW          = DW_DEF,
    parameter int  SYNC_STAGES = 2,
    localparam int DW2         = 2 * DW
) (
    input logic            i_clk,
    input logic            i_rst,
    ms_muldiv_seq_if.slave bus
);

    localparam int CW = $clog2(DW);

    state_e          r_state, w_state_nxt;
    op_e             r_op;
    logic [CW-1:0]   r_cnt;
    logic [DW2:0]    r_acc, w_acc_nxt;
    logic [DW-1:0]   r_a;
    logic [DW:0]     r_ma, r_mb;
    logic            r_sa, r_sb, r_dz;
    logic [DW2-1:0]  r_led;
    logic            r_done, r_err;

    logic            w_accept, w_ready, w_load, w_signed, w_div;
    logic [DW-1:0]   w_a_in, w_b_in;
    logic signed [32:0] w_a_ext, w_b_ext;
    logic [DW:0]     w_ma, w_mb, w_upper, w_sum, w_shl;
    logic [DW+1:0]   w_diff;

    ms_start_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (bus.i_start),
        .o_accept (w_accept)
    );

    assign w_signed = bus.i_op[0];
    assign w_div    = bus.i_op[1];
    assign w_a_in   = bus.i_sw[DW2-1:DW];
    assign w_b_in   = bus.i_sw[DW-1:0];
    assign w_a_ext  = signed'({{(33-DW){w_signed & w_a_in[DW-1]}}, w_a_in});
    assign w_b_ext  = signed'({{(33-DW){w_signed & w_b_in[DW-1]}}, w_b_in});
    assign w_ma     = (DW+1)'(abs_ext(w_a_ext));
    assign w_mb     = (DW+1)'(abs_ext(w_b_ext));

    // Ready stays low through the done cycle so the two never overlap.
    assign w_ready = (r_state == S_IDLE) && !r_done;
    assign w_load  = w_ready && w_accept;

    function automatic logic [DW2-1:0] fix_result(input op_e op, input logic [DW2-1:0] acc,
                                                  input logic [DW-1:0] a_raw,
                                                  input logic sa, input logic sb, input logic dz);
        logic [DW-1:0]  q, r;
        logic [DW2-1:0] res;
        q = acc[DW-1:0];
        r = acc[DW2-1:DW];
        if (op == OP_DIVS) begin
            if (sa ^ sb) q = -q;
            if (sa)      r = -r;
        end
        case (op)
            OP_MULU: res = acc;
            OP_MULS: res = (sa ^ sb) ? -acc : acc;
            default: res = dz ? {a_raw, {DW{1'b1}}} : {r, q};
        endcase
        return res;
    endfunction

    // Mul: acc = {partial sum, multiplier}; Div: acc = {remainder, dividend/quotient}.
    always_comb begin
        w_upper = r_acc[DW2:DW];
        w_sum   = r_acc[0] ? w_upper + r_ma : w_upper;
        w_shl   = r_acc[DW2-1:DW-1];
        w_diff  = {1'b0, w_shl} - {1'b0, r_mb};
        if (!r_op[1]) begin
            w_acc_nxt = {1'b0, w_sum, r_acc[DW-1:1]};
        end else if (w_diff[DW+1]) begin
            w_acc_nxt = {w_shl, r_acc[DW-2:0], 1'b0};
        end else begin
            w_acc_nxt = {w_diff[DW:0], r_acc[DW-2:0], 1'b1};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_state_nxt = S_CALC;
            S_CALC:  if (r_dz || r_cnt == CW'(DW-1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_led   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_load) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_FIX) begin
                r_led  <= fix_result(r_op, r_acc[DW2-1:0], r_a, r_sa, r_sb, r_dz);
                r_done <= 1'b1;
                r_err  <= r_dz;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_op  <= op_e'(bus.i_op);
            r_a   <= w_a_in;
            r_ma  <= w_ma;
            r_mb  <= w_mb;
            r_sa  <= w_a_ext[32];
            r_sb  <= w_b_ext[32];
            r_dz  <= w_div && (w_b_in == '0);
            r_acc <= {{(DW+1){1'b0}}, w_div ? w_ma[DW-1:0] : w_mb[DW-1:0]};
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign bus.o_led   = r_led;
    assign bus.o_ready = w_ready;
    assign bus.o_done  = r_done;
    assign bus.o_err   = r_err;

endmodule

// File: tb/tb_ms_muldiv_seq.sv
// Directed table-driven bench for ms_muldiv_seq at DW=16, plus handshake/reset corner sequences.
module tb_ms_muldiv_seq;
    import pkg_mult::*;

    localparam int DW  = 16;
    localparam int DW2 = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ms_muldiv_seq_if #(.DW(DW)) bus ();

    ms_muldiv_seq #(.DW(DW), .SYNC_STAGES(2)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] led;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.i_op    = op;
        bus.i_sw    = {a, b};
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_start = 1'b1;
    endtask

    task automatic wait_latch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.o_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Latency counted in rising edges after the edge that latched the operands.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        bit ok_l, ok_d;
        int lat;
        start_op(v.op, v.a, v.b);
        wait_latch(ok_l);
        check({tag, "_latch"}, 32'(ok_l), 32'd1);
        check({tag, "_err_clr"}, 32'(bus.o_err), 32'd0);
        wait_done(lat, ok_d);
        check({tag, "_done_seen"}, 32'(ok_d), 32'd1);
        if (ok_d) begin
            check({tag, "_led"}, bus.o_led, v.led);
            check({tag, "_err"}, 32'(bus.o_err), 32'(v.err));
            check({tag, "_lat"}, 32'(lat), 32'(v.lat));
            check({tag, "_rdy_at_done"}, 32'(bus.o_ready), 32'd0);
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, 32'(bus.o_done), 32'd0);
            check({tag, "_rdy_after"}, 32'(bus.o_ready), 32'd1);
            check({tag, "_led_hold"}, bus.o_led, v.led);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int   dones;
        logic [31:0] led_at_done;
        bit   ok;

        vecs[0]  = '{2'b01, 16'hFF00, 16'hFF00, 32'h0001_0000, 1'b0, 17};
        vecs[1]  = '{2'b01, 16'h0007, 16'h0007, 32'h0000_0031, 1'b0, 17};
        vecs[2]  = '{2'b00, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 17};
        vecs[3]  = '{2'b11, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 1'b0, 17};
        vecs[4]  = '{2'b11, 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b0, 17};
        vecs[5]  = '{2'b10, 16'h0064, 16'h0000, 32'h0064_FFFF, 1'b1, 2};
        vecs[6]  = '{2'b10, 16'h0064, 16'h0007, 32'h0002_000E, 1'b0, 17};
        vecs[7]  = '{2'b01, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 17};
        vecs[8]  = '{2'b11, 16'h0007, 16'hFFFE, 32'h0001_FFFD, 1'b0, 17};
        vecs[9]  = '{2'b10, 16'hFFFF, 16'h0010, 32'h000F_0FFF, 1'b0, 17};
        vecs[10] = '{2'b11, 16'hFFF9, 16'h0000, 32'hFFF9_FFFF, 1'b1, 2};
        vecs[11] = '{2'b00, 16'h1234, 16'h0000, 32'h0000_0000, 1'b0, 17};
        vecs[12] = '{2'b01, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 1'b0, 17};

        bus.i_start = 1'b1;
        bus.i_op    = 2'b00;
        bus.i_sw    = '0;
        #12;
        check("rst_led", bus.o_led, 32'h0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Second start and operand change during a multiply must be ignored.
        start_op(2'b00, 16'd3, 16'd5);
        wait_latch(ok);
        check("midop_latch", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        bus.i_sw    = 32'hFFFF_FFFF;
        bus.i_op    = 2'b11;
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_start = 1'b1;
        dones = 0;
        led_at_done = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                dones++;
                led_at_done = bus.o_led;
            end
        end
        check("midop_dones", 32'(dones), 32'd1);
        check("midop_led", led_at_done, 32'd15);
        check("midop_ready", 32'(bus.o_ready), 32'd1);

        // Start held low for a long time yields a single operation.
        @(negedge clk);
        bus.i_op    = 2'b00;
        bus.i_sw    = {16'd2, 16'd3};
        bus.i_start = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                dones++;
                led_at_done = bus.o_led;
            end
        end
        bus.i_start = 1'b1;
        check("hold_dones", 32'(dones), 32'd1);
        check("hold_led", led_at_done, 32'd6);
        repeat (5) @(negedge clk);
        check("hold_ready", 32'(bus.o_ready), 32'd1);

        // Asynchronous reset in the middle of CALC.
        run_vec("pre_rst", '{2'b10, 16'h0005, 16'h0000, 32'h0005_FFFF, 1'b1, 2});
        start_op(2'b01, 16'h0100, 16'h0003);
        wait_latch(ok);
        check("arst_latch", 32'(ok), 32'd1);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led", bus.o_led, 32'h0);
        check("arst_ready", 32'(bus.o_ready), 32'd1);
        check("arst_done", 32'(bus.o_done), 32'd0);
        check("arst_err", 32'(bus.o_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) dones++;
        end
        check("arst_no_done", 32'(dones), 32'd0);
        run_vec("post_rst", vecs[12]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
